// File: rtl/program_loader_pkg.sv
// Shared definitions for the UART program loader: controller and receiver state
// encodings, default sizing constants and the word-to-byte address helper.
package program_loader_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int DEFAULT_IMEM_WORDS   = 256;

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA,
    RUN,
    ERR
  } loaderState_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rxState_t;

  function automatic logic [31:0] wordAddr(input logic [31:0] index);
    return index << 2;
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Instruction-memory write port, driven by the loader while the CPU is held off.
interface program_loader_if;

  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;

  modport master (output imem_we, imem_addr, imem_data);
  modport slave  (input  imem_we, imem_addr, imem_data);

endinterface

// File: rtl/program_loader_uart_rx.sv
// 8N1 UART receiver: synchronizes rx, validates the start bit at half a bit time
// and samples each following bit mid-bit, flagging a low stop bit as a framing error.
module uart_rx
  import program_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  rxState_t         state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [2:0]       bitIdx, bitIdxNext;
  logic [7:0]       shiftReg, shiftNext;
  logic             byteValidNext, frameErrNext;
  logic             rxMeta, rxSync, rxPrev;

  // The synchronizer and edge-detect flops idle high so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxMeta <= 1'b1;
      rxSync <= 1'b1;
      rxPrev <= 1'b1;
    end else begin
      rxMeta <= rx;
      rxSync <= rxMeta;
      rxPrev <= rxSync;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RX_IDLE;
      cnt        <= '0;
      bitIdx     <= '0;
      shiftReg   <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= stateNext;
      cnt        <= cntNext;
      bitIdx     <= bitIdxNext;
      shiftReg   <= shiftNext;
      byte_valid <= byteValidNext;
      frame_err  <= frameErrNext;
      if (byteValidNext) begin
        byte_out <= shiftReg;
      end
    end
  end

  // A start bit that is high again at the half-bit point was a glitch and is dropped.
  always_comb begin
    stateNext     = state;
    cntNext       = cnt;
    bitIdxNext    = bitIdx;
    shiftNext     = shiftReg;
    byteValidNext = 1'b0;
    frameErrNext  = 1'b0;
    unique case (state)
      RX_IDLE: begin
        if (rxPrev && !rxSync) begin
          stateNext = RX_START;
          cntNext   = '0;
        end
      end
      RX_START: begin
        if (cnt == HALF_LAST) begin
          cntNext    = '0;
          bitIdxNext = '0;
          stateNext  = rxSync ? RX_IDLE : RX_DATA;
        end else begin
          cntNext = cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt == BIT_LAST) begin
          cntNext   = '0;
          shiftNext = {rxSync, shiftReg[7:1]};
          if (bitIdx == 3'd7) begin
            stateNext = RX_STOP;
          end else begin
            bitIdxNext = bitIdx + 3'd1;
          end
        end else begin
          cntNext = cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt == BIT_LAST) begin
          cntNext   = '0;
          stateNext = RX_IDLE;
          if (rxSync) begin
            byteValidNext = 1'b1;
          end else begin
            frameErrNext = 1'b1;
          end
        end else begin
          cntNext = cnt + 1'b1;
        end
      end
      default: stateNext = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/program_loader.sv
// Boot loader: receives a little-endian word count and that many little-endian
// words over UART, writes them to instruction memory, then releases the CPU.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int IMEM_WORDS   = DEFAULT_IMEM_WORDS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  program_loader_if.master imem,
  output logic             cpu_run,
  output logic             load_err
);

  localparam int IDX_W = $clog2(IMEM_WORDS + 1);

  loaderState_t     state, stateNext;
  logic [15:0]      wordCount, wordCountNext;
  logic [IDX_W-1:0] wordIndex, wordIndexNext;
  logic [1:0]       byteIdx, byteIdxNext;
  logic [23:0]      partWord, partWordNext;
  logic             weReg, weNext;
  logic [31:0]      addrReg, addrNext;
  logic [31:0]      dataReg, dataNext;
  logic [31:0]      lenFull;
  logic [31:0]      wordIndexPlusOne;
  logic [7:0]       rxByte;
  logic             rxValid;
  logic             rxFrameErr;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) uartRx (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .byte_out   (rxByte),
    .byte_valid (rxValid),
    .frame_err  (rxFrameErr)
  );

  assign lenFull          = {16'd0, rxByte, wordCount[7:0]};
  assign wordIndexPlusOne = 32'(wordIndex) + 32'd1;

  assign imem.imem_we   = weReg;
  assign imem.imem_addr = addrReg;
  assign imem.imem_data = dataReg;
  assign cpu_run        = (state == RUN);
  assign load_err       = (state == ERR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= LEN_LO;
      wordCount <= '0;
      wordIndex <= '0;
      byteIdx   <= '0;
      partWord  <= '0;
      weReg     <= 1'b0;
      addrReg   <= '0;
      dataReg   <= '0;
    end else begin
      state     <= stateNext;
      wordCount <= wordCountNext;
      wordIndex <= wordIndexNext;
      byteIdx   <= byteIdxNext;
      partWord  <= partWordNext;
      weReg     <= weNext;
      addrReg   <= addrNext;
      dataReg   <= dataNext;
    end
  end

  // The word index advances during the write cycle itself, so RUN (and cpu_run)
  // follows one cycle after the final imem_we pulse.
  always_comb begin
    stateNext     = state;
    wordCountNext = wordCount;
    wordIndexNext = wordIndex;
    byteIdxNext   = byteIdx;
    partWordNext  = partWord;
    weNext        = 1'b0;
    addrNext      = addrReg;
    dataNext      = dataReg;
    unique case (state)
      LEN_LO: begin
        if (rxFrameErr) begin
          stateNext = ERR;
        end else if (rxValid) begin
          wordCountNext = {8'd0, rxByte};
          stateNext     = LEN_HI;
        end
      end
      LEN_HI: begin
        if (rxFrameErr) begin
          stateNext = ERR;
        end else if (rxValid) begin
          wordCountNext = {rxByte, wordCount[7:0]};
          wordIndexNext = '0;
          byteIdxNext   = '0;
          if (lenFull > 32'(IMEM_WORDS)) begin
            stateNext = ERR;
          end else if (lenFull == 32'd0) begin
            stateNext = RUN;
          end else begin
            stateNext = DATA;
          end
        end
      end
      DATA: begin
        if (weReg) begin
          wordIndexNext = wordIndex + 1'b1;
          if (wordIndexPlusOne == {16'd0, wordCount}) begin
            stateNext = RUN;
          end
        end else if (rxFrameErr) begin
          stateNext = ERR;
        end else if (rxValid) begin
          byteIdxNext = byteIdx + 2'd1;
          unique case (byteIdx)
            2'd0: partWordNext[7:0]   = rxByte;
            2'd1: partWordNext[15:8]  = rxByte;
            2'd2: partWordNext[23:16] = rxByte;
            default: begin
              weNext   = 1'b1;
              addrNext = wordAddr(32'(wordIndex));
              dataNext = {rxByte, partWord};
            end
          endcase
        end
      end
      RUN: begin
      end
      ERR: begin
      end
      default: stateNext = ERR;
    endcase
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed load scenarios plus randomized
// loads checked against a protocol-level reference model.
module tb_program_loader;

  localparam int CPB   = 16;
  localparam int WORDS = 256;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic rx    = 1'b1;
  logic cpuRun, loadErr;

  program_loader_if imemIf();

  program_loader #(.CLKS_PER_BIT(CPB), .IMEM_WORDS(WORDS)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .imem     (imemIf),
    .cpu_run  (cpuRun),
    .load_err (loadErr)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int cycle      = 0;
  int runCycle   = -1;
  bit runSeen    = 1'b0;
  int byteCount  = 0;
  int badIdx     = -1;

  logic [31:0] wrAddr[$];
  logic [31:0] wrData[$];
  int          wrCycle[$];
  logic [7:0]  stream[$];
  logic [31:0] expAddr[$];
  logic [31:0] expData[$];
  bit          expRun, expErr;

  always @(posedge clk) cycle++;

  // Write log, run-start time and received-byte count, all sampled mid-cycle.
  always @(negedge clk) begin
    if (imemIf.imem_we === 1'b1) begin
      wrAddr.push_back(imemIf.imem_addr);
      wrData.push_back(imemIf.imem_data);
      wrCycle.push_back(cycle);
    end
    if (cpuRun === 1'b1 && !runSeen) begin
      runSeen  = 1'b1;
      runCycle = cycle;
    end
    if (dut.uartRx.byte_valid === 1'b1) byteCount++;
  end

  task automatic clearLog();
    wrAddr.delete(); wrData.delete(); wrCycle.delete();
    runSeen = 1'b0; runCycle = -1; byteCount = 0; badIdx = -1;
    stream.delete(); expAddr.delete(); expData.delete();
  endtask

  task automatic doReset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    clearLog();
  endtask

  task automatic sendByte(input logic [7:0] b, input logic stopBit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stopBit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic sendStream();
    for (int i = 0; i < stream.size(); i++) sendByte(stream[i], (i == badIdx) ? 1'b0 : 1'b1);
    repeat (5) @(negedge clk);
  endtask

  // Protocol-level model: header gives N; each complete, cleanly framed word lands at 4*w.
  task automatic modelLoad();
    int n;
    expAddr.delete(); expData.delete(); expRun = 1'b0; expErr = 1'b0;
    if (badIdx == 0 || badIdx == 1) begin expErr = 1'b1; return; end
    n = int'(stream[0]) + 256 * int'(stream[1]);
    if (n > WORDS) begin expErr = 1'b1; return; end
    for (int w = 0; w < n; w++) begin
      int base = 2 + 4 * w;
      if (badIdx >= base && badIdx < base + 4) begin expErr = 1'b1; return; end
      if (base + 4 > stream.size()) return;
      expAddr.push_back(32'(4 * w));
      expData.push_back({stream[base+3], stream[base+2], stream[base+1], stream[base]});
    end
    expRun = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    compared++; if (imemIf.imem_we !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_we: got %b want 0", imemIf.imem_we); end
    compared++; if (imemIf.imem_addr !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_addr: got %h want 0", imemIf.imem_addr); end
    compared++; if (imemIf.imem_data !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_data: got %h want 0", imemIf.imem_data); end
    compared++; if (cpuRun !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_run: got %b want 0", cpuRun); end
    compared++; if (loadErr !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_err: got %b want 0", loadErr); end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    clearLog();
  endtask

  task automatic test_two_word_load();
    doReset();
    stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h08, 8'h20, 8'hFF, 8'hFF, 8'h09, 8'h21};
    expAddr = '{32'h0, 32'h4};
    expData = '{32'h20080013, 32'h2109FFFF};
    sendStream();
    compared++; if (wrAddr.size() != 2) begin mismatched++; $display("[TB] FAIL two_word_count: got %0d want 2", wrAddr.size()); end
    for (int i = 0; i < 2 && i < wrAddr.size(); i++) begin
      compared++;
      if (wrAddr[i] !== expAddr[i] || wrData[i] !== expData[i]) begin
        mismatched++; $display("[TB] FAIL two_word_write%0d: got %h@%h want %h@%h", i, wrData[i], wrAddr[i], expData[i], expAddr[i]);
      end
    end
    compared++;
    if (wrCycle.size() != 2 || runCycle != wrCycle[1] + 1) begin
      mismatched++; $display("[TB] FAIL two_word_run_timing: run at %0d, writes %0d", runCycle, wrCycle.size());
    end
    compared++; if (loadErr !== 1'b0) begin mismatched++; $display("[TB] FAIL two_word_err: got %b want 0", loadErr); end
  endtask

  task automatic test_run_ignores();
    stream = '{8'h01, 8'h00, 8'h5A};
    badIdx = 2;
    sendStream();
    compared++; if (wrAddr.size() != 2) begin mismatched++; $display("[TB] FAIL run_ignore_writes: got %0d want 2", wrAddr.size()); end
    compared++; if (cpuRun !== 1'b1 || loadErr !== 1'b0) begin mismatched++; $display("[TB] FAIL run_ignore_flags: run %b err %b want 1 0", cpuRun, loadErr); end
    reset = 1'b0;
    #1;
    compared++;
    if (cpuRun !== 1'b0 || imemIf.imem_addr !== 32'h0 || imemIf.imem_data !== 32'h0) begin
      mismatched++; $display("[TB] FAIL async_reset: run %b addr %h data %h want 0 0 0", cpuRun, imemIf.imem_addr, imemIf.imem_data);
    end
    @(negedge clk);
  endtask

  task automatic test_zero_length();
    doReset();
    stream = '{8'h00, 8'h00};
    sendStream();
    compared++; if (cpuRun !== 1'b1) begin mismatched++; $display("[TB] FAIL zero_len_run: got %b want 1", cpuRun); end
    compared++; if (wrAddr.size() != 0) begin mismatched++; $display("[TB] FAIL zero_len_writes: got %0d want 0", wrAddr.size()); end
  endtask

  task automatic test_oversize();
    doReset();
    stream = '{8'h01, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    sendStream();
    compared++; if (loadErr !== 1'b1 || cpuRun !== 1'b0) begin mismatched++; $display("[TB] FAIL oversize_flags: err %b run %b want 1 0", loadErr, cpuRun); end
    compared++; if (wrAddr.size() != 0) begin mismatched++; $display("[TB] FAIL oversize_writes: got %0d want 0", wrAddr.size()); end
  endtask

  task automatic test_frame_error();
    doReset();
    stream = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    badIdx = 4;
    sendStream();
    compared++; if (loadErr !== 1'b1 || cpuRun !== 1'b0) begin mismatched++; $display("[TB] FAIL frame_flags: err %b run %b want 1 0", loadErr, cpuRun); end
    compared++; if (wrAddr.size() != 0) begin mismatched++; $display("[TB] FAIL frame_writes: got %0d want 0", wrAddr.size()); end
  endtask

  task automatic test_glitch();
    doReset();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    compared++; if (byteCount != 0) begin mismatched++; $display("[TB] FAIL glitch_bytes: got %0d want 0", byteCount); end
    sendByte(8'h05, 1'b1);
    compared++; if (byteCount != 1) begin mismatched++; $display("[TB] FAIL glitch_next_count: got %0d want 1", byteCount); end
    compared++; if (dut.uartRx.byte_out !== 8'h05) begin mismatched++; $display("[TB] FAIL glitch_next_byte: got %h want 05", dut.uartRx.byte_out); end
  endtask

  task automatic test_reset_mid_load();
    doReset();
    stream = '{8'h01, 8'h00, 8'hAA, 8'hBB};
    sendStream();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    clearLog();
    stream = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    sendStream();
    compared++; if (wrAddr.size() != 1) begin mismatched++; $display("[TB] FAIL mid_reset_count: got %0d want 1", wrAddr.size()); end
    compared++;
    if (wrAddr.size() < 1 || wrAddr[0] !== 32'h0 || wrData[0] !== 32'hDDCCBBAA) begin
      mismatched++; $display("[TB] FAIL mid_reset_write: %0d writes, want DDCCBBAA@0", wrAddr.size());
    end
    compared++;
    if (wrCycle.size() < 1 || runCycle != wrCycle[0] + 1) begin
      mismatched++; $display("[TB] FAIL mid_reset_run: run at %0d, writes %0d", runCycle, wrCycle.size());
    end
  endtask

  task automatic test_random_loads();
    for (int iter = 0; iter < 5; iter++) begin
      int mode, n;
      doReset();
      mode = (iter < 4) ? iter : int'($urandom_range(0, 3));
      n = (mode == 0) ? int'($urandom_range(257, 600)) : int'($urandom_range(1, 5));
      stream.push_back(8'(n));
      stream.push_back(8'(n >> 8));
      if (mode == 0) begin
        repeat (4) stream.push_back(8'($urandom));
      end else begin
        repeat (4 * n) stream.push_back(8'($urandom));
        if (mode == 3) begin
          void'(stream.pop_back());
          void'(stream.pop_back());
        end else begin
          repeat (2) stream.push_back(8'($urandom));
        end
      end
      if (mode == 1) badIdx = int'($urandom_range(2, 1 + 4 * n));
      sendStream();
      modelLoad();
      compared++;
      if (wrAddr.size() != expAddr.size()) begin
        mismatched++; $display("[TB] FAIL rand%0d_count: got %0d want %0d", iter, wrAddr.size(), expAddr.size());
      end
      for (int i = 0; i < expAddr.size() && i < wrAddr.size(); i++) begin
        compared++;
        if (wrAddr[i] !== expAddr[i] || wrData[i] !== expData[i]) begin
          mismatched++; $display("[TB] FAIL rand%0d_write%0d: got %h@%h want %h@%h", iter, i, wrData[i], wrAddr[i], expData[i], expAddr[i]);
        end
      end
      compared++;
      if (cpuRun !== expRun || loadErr !== expErr) begin
        mismatched++; $display("[TB] FAIL rand%0d_flags: run %b err %b want %b %b", iter, cpuRun, loadErr, expRun, expErr);
      end
      if (expRun && expAddr.size() > 0) begin
        compared++;
        if (wrCycle.size() == 0 || runCycle != wrCycle[wrCycle.size()-1] + 1) begin
          mismatched++; $display("[TB] FAIL rand%0d_run_timing: run at %0d", iter, runCycle);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_word_load();
    test_run_ignores();
    test_zero_length();
    test_oversize();
    test_frame_error();
    test_glitch();
    test_reset_mid_load();
    test_random_loads();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per UART bit (100 MHz / 115200).
REQ-002 SHALL have parameter IMEM_WORDS, default 256, meaning instruction-memory capacity in 32-bit words.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset (0 = in reset).
REQ-006 SHALL have port rx, input, 1, UART serial line, idle high, asynchronous to clk.
REQ-007 SHALL have port imem_we, output, 1, one-cycle write strobe to instruction memory.
REQ-008 SHALL have port imem_addr, output, 32, word-aligned byte address (word_index*4).
REQ-009 SHALL have port imem_data, output, 32, instruction word to write.
REQ-010 SHALL have port cpu_run, output, 1, pipeline enable for the datapath, high once loading completes.
REQ-011 SHALL have port load_err, output, 1, sticky error flag.

Function
REQ-012 SHALL feed rx through a 2-flop synchronizer before any use.
REQ-013 SHALL detect a start bit on a synchronized falling edge, re-check it low at CLKS_PER_BIT/2, and abandon it as a glitch if high.
REQ-014 SHALL sample 8 data bits LSB-first at mid-bit, then the stop bit, and pulse byte_valid for one cycle at the stop-bit sample.
REQ-015 SHALL treat a low stop bit as a framing error: byte discarded, controller enters ERR.
REQ-016 SHALL implement the protocol as a 16-bit little-endian word count N, then N words of 4 bytes each, little-endian.
REQ-017 SHALL implement controller states LEN_LO, LEN_HI, DATA, RUN, ERR; reset state LEN_LO.
REQ-018 SHALL transition LEN_LO->LEN_HI on byte_valid, latching N[7:0].
REQ-019 SHALL, in LEN_HI on byte_valid: go to ERR if N > IMEM_WORDS; else RUN if N == 0; else DATA.
REQ-020 SHALL, in DATA, assemble bytes at byte index 0..3 into imem_data[8i+7:8i].
REQ-021 SHALL assert imem_we for exactly one cycle, the cycle after the 4th byte_valid, with imem_addr = word_index*4 stable that cycle.
REQ-022 SHALL, on that write, increment word_index and go to RUN if word_index+1 == N, else stay in DATA with byte index 0.
REQ-023 SHALL, in RUN, hold cpu_run = 1, ignore all further rx traffic, and never assert imem_we.
REQ-024 SHALL, in ERR, hold load_err = 1, cpu_run = 0, and imem_we = 0 until reset.
REQ-025 SHALL apply no timeout; a partial word waits indefinitely.
REQ-026 SHALL use a word_index wide enough to hold IMEM_WORDS without wrap.
REQ-027 SHALL keep imem_addr and imem_data at their last values while imem_we is 0.

Reset
REQ-028 SHALL, with reset low, asynchronously force: state LEN_LO, imem_we 0, imem_addr 0, imem_data 0, cpu_run 0, load_err 0, word_index 0, byte index 0, UART receiver idle, synchronizer flops 1.
REQ-029 SHALL, on reset asserted mid-byte or mid-load, discard the partial data; the next load restarts from the length header.
REQ-030 SHALL release reset synchronously to clk (external synchronizer); the first receive edge is recognized no earlier than 2 cycles after release.

Structure
REQ-031 SHALL place the controller state encoding and the default CLKS_PER_BIT and IMEM_WORDS constants in the shared package.
REQ-032 SHALL implement the UART receiver (REQ-012..015) as sub-module uart_rx with outputs byte_out[7:0], byte_valid, frame_err.
REQ-033 SHALL keep the word assembly and controller FSM in program_loader itself.

Verification
REQ-034 SHALL cover, with CLKS_PER_BIT=16: send 02 00, then 13 00 08 20, then FF FF 09 21 -> writes 0x20080013 @0x0 and 0x2109FFFF @0x4, then cpu_run=1 one cycle after the second imem_we.
REQ-035 SHALL cover: send 00 00 -> cpu_run=1 with no imem_we pulse.
REQ-036 SHALL cover: send 01 01 (N=257 > 256) -> load_err=1, cpu_run=0, and later bytes cause no write.
REQ-037 SHALL cover: a byte with stop bit 0 during DATA -> load_err=1, and no write for the affected word.
REQ-038 SHALL cover: rx low pulse of 4 cycles -> no byte_valid; a following valid byte 0x05 is received correctly.
REQ-039 SHALL cover: reset pulsed after 2 of 4 bytes, then a full N=1 load with AA BB CC DD -> single write 0xDDCCBBAA @0x0, then cpu_run=1.
